// File: rtl/pll_reconfig_master.sv
// Purpose: turns single read/write commands into Avalon-MM transfers, optionally polling a busy flag after writes.
// Latency: 3 cycles handshake-to-rsp_valid for zero-wait accesses; each wait state and poll round adds cycles.
// Backpressure: cmd_ready only in IDLE, nothing is queued; avm_m0_waitrequest stalls the transfer with outputs held.
// Optional build macro PLL_RECONFIG_MASTER_TIMEOUT_EN adds a poll timeout reported through rsp_error.
module pll_reconfig_master #(
  parameter int MASTER_ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH           = 32,
  parameter int POLL_ADDRESS         = 0,
  parameter int BUSY_BIT             = 0,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                            csi_master_clk_clk,
  input  logic                            csi_master_clk_reset_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic                            cmd_poll,
  input  logic [MASTER_ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0]           cmd_writedata,
  output logic                            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_readdata,
  output logic                            rsp_error,
  output logic [MASTER_ADDRESS_WIDTH-1:0] avm_m0_address,
  output logic [DATA_WIDTH/8-1:0]         avm_m0_byteenable,
  output logic                            avm_m0_read,
  output logic                            avm_m0_write,
  output logic [DATA_WIDTH-1:0]           avm_m0_writedata,
  input  logic [DATA_WIDTH-1:0]           avm_m0_readdata,
  input  logic                            avm_m0_waitrequest
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACCESS   = 3'd1;
  localparam logic [2:0] POLL_RD  = 3'd2;
  localparam logic [2:0] POLL_GAP = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [MASTER_ADDRESS_WIDTH-1:0] POLL_ADDR = MASTER_ADDRESS_WIDTH'(POLL_ADDRESS);

  logic [2:0] state;
  logic       poll_q;    // write command asked for busy polling
  logic       cmd_fire;
  logic       status_busy;
  logic       tmo_hit;   // poll time budget used up

  assign cmd_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign status_busy = avm_m0_readdata[BUSY_BIT];

  // Byte lanes are only meaningful while a transfer is on the bus.
  assign avm_m0_byteenable = {(DATA_WIDTH/8){avm_m0_read | avm_m0_write}};

`ifdef PLL_RECONFIG_MASTER_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err;

  assign tmo_hit   = (tmo_cnt == CNT_MAX);
  assign rsp_error = rsp_valid && tmo_err;

  // Count cycles spent polling, starting at 0 on POLL_RD entry; hold at the limit.
  always_ff @(posedge csi_master_clk_clk or negedge csi_master_clk_reset_n) begin
    if (!csi_master_clk_reset_n) begin
      tmo_cnt <= '0;
    end else if (state == POLL_RD || state == POLL_GAP) begin
      if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Remember that polling was abandoned so the response carries the error.
  always_ff @(posedge csi_master_clk_clk or negedge csi_master_clk_reset_n) begin
    if (!csi_master_clk_reset_n) begin
      tmo_err <= 1'b0;
    end else if (state == IDLE) begin
      tmo_err <= 1'b0;
    end else if (tmo_hit && ((state == POLL_RD && !avm_m0_waitrequest) || state == POLL_GAP)) begin
      tmo_err <= 1'b1;
    end
  end
`else
  // Without the timeout feature polling never gives up and TIMEOUT_CYCLES has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  // Command sequencing and registered Avalon master outputs.
  always_ff @(posedge csi_master_clk_clk or negedge csi_master_clk_reset_n) begin
    if (!csi_master_clk_reset_n) begin
      state            <= IDLE;
      poll_q           <= 1'b0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
      avm_m0_read      <= 1'b0;
      avm_m0_write     <= 1'b0;
      rsp_readdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            state            <= ACCESS;
            poll_q           <= cmd_write && cmd_poll;
            avm_m0_address   <= cmd_address;
            avm_m0_writedata <= cmd_writedata;
            avm_m0_write     <= cmd_write;
            avm_m0_read      <= !cmd_write;
          end
        end
        ACCESS: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_write <= 1'b0;
            if (avm_m0_read) rsp_readdata <= avm_m0_readdata;
            if (poll_q) begin
              // Status read follows the write directly; the gap rule only applies between polls.
              state          <= POLL_RD;
              avm_m0_read    <= 1'b1;
              avm_m0_address <= POLL_ADDR;
            end else begin
              state       <= RESP;
              avm_m0_read <= 1'b0;
            end
          end
        end
        POLL_RD: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_read  <= 1'b0;
            rsp_readdata <= avm_m0_readdata;
            if (!status_busy || tmo_hit) state <= RESP;
            else                         state <= POLL_GAP;
          end
        end
        POLL_GAP: begin
          if (tmo_hit) begin
            state <= RESP;
          end else begin
            state       <= POLL_RD;
            avm_m0_read <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Directed bench: vector table of single commands plus hand-written multi-cycle sequences.
// A bus responder supplies programmable wait states and a per-command list of read words.
// Outputs are sampled 1 ns after the rising edge; bus activity is observed on the falling edge.
module tb_pll_reconfig_master;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          csi_master_clk_clk = 1'b0;
  logic          csi_master_clk_reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic          cmd_poll = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_writedata = '0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_readdata;
  logic          rsp_error;
  logic [AW-1:0] avm_m0_address;
  logic [3:0]    avm_m0_byteenable;
  logic          avm_m0_read;
  logic          avm_m0_write;
  logic [DW-1:0] avm_m0_writedata;
  logic [DW-1:0] avm_m0_readdata = '0;
  logic          avm_m0_waitrequest = 1'b0;

  pll_reconfig_master #(
    .MASTER_ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .POLL_ADDRESS(0),
    .BUSY_BIT(0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .csi_master_clk_clk(csi_master_clk_clk),
    .csi_master_clk_reset_n(csi_master_clk_reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_poll(cmd_poll),
    .cmd_address(cmd_address),
    .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid),
    .rsp_readdata(rsp_readdata),
    .rsp_error(rsp_error),
    .avm_m0_address(avm_m0_address),
    .avm_m0_byteenable(avm_m0_byteenable),
    .avm_m0_read(avm_m0_read),
    .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  always #5 csi_master_clk_clk = ~csi_master_clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge csi_master_clk_clk);
    #1;
  endtask

  // Responder configuration and state.
  int          wait_n = 0;
  int          ws_cnt = 0;
  logic [31:0] rd_words [8];
  int          rd_n = 1;
  int          rd_idx = 0;

  // Falling-edge snapshot of the bus and running counters.
  logic          s_rd = 1'b0, s_wr = 1'b0, s_wait = 1'b0;
  logic          p_stall = 1'b0, p_rd_done = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  int            bus_cyc = 0, wr_done = 0, rd_done = 0, poll_rd = 0, rsp_cnt = 0, hs_cnt = 0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_wdata = '0;
  logic          f_wr = 1'b0;

  // Responder: advance wait-state and read-word pointers from the cycle that just ended.
  always @(posedge csi_master_clk_clk) begin
    #1;
    if (s_rd || s_wr) begin
      if (s_wait) begin
        ws_cnt++;
      end else begin
        ws_cnt = 0;
        if (s_rd && rd_idx < rd_n - 1) rd_idx++;
      end
    end else begin
      ws_cnt = 0;
    end
    avm_m0_waitrequest = (avm_m0_read || avm_m0_write) && (ws_cnt < wait_n);
    avm_m0_readdata    = rd_words[rd_idx];
  end

  // Bus monitor: protocol rules checked every active cycle.
  always @(negedge csi_master_clk_clk) begin
    s_rd   = avm_m0_read;
    s_wr   = avm_m0_write;
    s_wait = avm_m0_waitrequest;
    if (csi_master_clk_reset_n) begin
      if (avm_m0_read || avm_m0_write) begin
        bus_cyc++;
        if (bus_cyc == 1) begin
          f_addr  = avm_m0_address;
          f_wdata = avm_m0_writedata;
          f_wr    = avm_m0_write;
        end
        chk("byteenable_full", avm_m0_byteenable, 4'hF);
        chk("rd_wr_exclusive", avm_m0_read & avm_m0_write, 1'b0);
        if (!avm_m0_waitrequest) begin
          if (avm_m0_write) wr_done++;
          if (avm_m0_read) begin
            rd_done++;
            if (avm_m0_address == 5'd0) poll_rd++;
          end
        end
      end
      if (p_stall) begin
        chk("stall_addr_stable", avm_m0_address, p_addr);
        chk("stall_wdata_stable", avm_m0_writedata, p_wdata);
        chk("stall_cmd_stable", {avm_m0_read, avm_m0_write}, {p_rd, p_wr});
      end
      if (p_rd_done) chk("read_gap", avm_m0_read, 1'b0);
      if (rsp_valid) begin
        rsp_cnt++;
        chk("resp_bus_idle", avm_m0_read | avm_m0_write, 1'b0);
      end
      if (cmd_valid && cmd_ready) hs_cnt++;
    end
    p_stall   = csi_master_clk_reset_n && (avm_m0_read || avm_m0_write) && avm_m0_waitrequest;
    p_rd_done = csi_master_clk_reset_n && avm_m0_read && !avm_m0_waitrequest;
    p_rd      = avm_m0_read;
    p_wr      = avm_m0_write;
    p_addr    = avm_m0_address;
    p_wdata   = avm_m0_writedata;
  end

  typedef struct {
    logic        wr;
    logic        poll;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          waits;
    int          busy_n;
    logic [31:0] busy_word;
    logic [31:0] rword;
    int          exp_lat;
    int          exp_bus;
    int          exp_wr;
    int          exp_rd;
    int          exp_poll;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic clear_counters();
    bus_cyc = 0; wr_done = 0; rd_done = 0; poll_rd = 0; rsp_cnt = 0; hs_cnt = 0;
  endtask

  task automatic load_slave(input int waits, input int busy_n, input logic [31:0] busy_word,
                            input logic [31:0] rword);
    wait_n = waits;
    rd_idx = 0;
    rd_n   = busy_n + 1;
    for (int k = 0; k < 8; k++) rd_words[k] = (k < busy_n) ? busy_word : rword;
  endtask

  task automatic issue(input logic wr, input logic poll, input logic [4:0] addr, input logic [31:0] wdata);
    cmd_valid     = 1'b1;
    cmd_write     = wr;
    cmd_poll      = poll;
    cmd_address   = addr;
    cmd_writedata = wdata;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    load_slave(v.waits, v.busy_n, v.busy_word, v.rword);
    clear_counters();
    tick();
    chk($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
    issue(v.wr, v.poll, v.addr, v.wdata);
    tick();
    cmd_valid = 1'b0;
    lat = 2;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d_rsp_error", i), rsp_error, 1'b0);
    chk($sformatf("v%0d_rsp_readdata", i), rsp_readdata, v.exp_rdata);
    tick();
    chk($sformatf("v%0d_rsp_pulse", i), rsp_valid, 1'b0);
    chk($sformatf("v%0d_ready_after", i), cmd_ready, 1'b1);
    chk($sformatf("v%0d_bus_cycles", i), bus_cyc, v.exp_bus);
    chk($sformatf("v%0d_writes", i), wr_done, v.exp_wr);
    chk($sformatf("v%0d_reads", i), rd_done, v.exp_rd);
    chk($sformatf("v%0d_poll_reads", i), poll_rd, v.exp_poll);
    chk($sformatf("v%0d_rsp_count", i), rsp_cnt, 1);
    chk($sformatf("v%0d_first_addr", i), f_addr, v.addr);
    chk($sformatf("v%0d_first_dir", i), f_wr, v.wr);
    if (v.wr) chk($sformatf("v%0d_first_wdata", i), f_wdata, v.wdata);
  endtask

  task automatic pulse_reset(input string nm);
    #2 csi_master_clk_reset_n = 1'b0;
    #1;
    chk({nm, "_read_low"}, avm_m0_read, 1'b0);
    chk({nm, "_write_low"}, avm_m0_write, 1'b0);
    chk({nm, "_no_rsp"}, rsp_valid, 1'b0);
    repeat (2) @(negedge csi_master_clk_clk);
    csi_master_clk_reset_n = 1'b1;
    tick();
    chk({nm, "_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vec_t fresh;
    int   n;
    int   lat;

    //          wr    poll  addr   wdata         wt bn busy_word     rword         lat bus w  r  p  rdata
    vecs[0] = '{1'b1, 1'b0, 5'h04, 32'hA5A5_0001, 0, 0, 32'h0,        32'h0,         3,  1, 1, 0, 0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 5'h02, 32'h0,         4, 0, 32'h0,        32'h1234_5678, 7,  5, 0, 1, 0, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 5'h07, 32'hDEAD_BEEF, 2, 0, 32'h0,        32'h0,         5,  3, 1, 0, 0, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 5'h1F, 32'h0,         0, 0, 32'h0,        32'hCAFE_F00D, 3,  1, 0, 1, 0, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 1'b1, 5'h01, 32'h0000_0003, 0, 3, 32'h0000_0081, 32'h0,        10, 5, 1, 4, 4, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 5'h0A, 32'h0000_0055, 1, 1, 32'h8000_0001, 32'h0000_00F0, 9, 6, 1, 2, 2, 32'h0000_00F0};
    vecs[6] = '{1'b0, 1'b1, 5'h03, 32'h0,         0, 0, 32'h0,        32'h0000_0001, 3,  1, 0, 1, 0, 32'h0000_0001};

    load_slave(0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge csi_master_clk_clk);
    @(negedge csi_master_clk_clk);
    csi_master_clk_reset_n = 1'b1;
    tick();
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_rd_wr", {avm_m0_read, avm_m0_write}, 2'b00);
    chk("reset_rsp", {rsp_valid, rsp_error}, 2'b00);
    chk("reset_addr", avm_m0_address, 5'h0);
    chk("reset_wdata", avm_m0_writedata, 32'h0);
    chk("reset_byteenable", avm_m0_byteenable, 4'h0);
    chk("reset_readdata", rsp_readdata, 32'h0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // cmd_valid held high: one extra command taken, and only once back in IDLE.
    load_slave(0, 0, 32'h0, 32'h0);
    clear_counters();
    tick();
    issue(1'b1, 1'b0, 5'h08, 32'h0000_0011);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("hold_ready_in_resp", cmd_ready, 1'b0);
    tick();
    chk("hold_ready_in_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("hold_handshakes", hs_cnt, 2);
    chk("hold_writes", wr_done, 2);
    chk("hold_responses", rsp_cnt, 2);

    // Status stuck busy.
    load_slave(0, 0, 32'h0, 32'h0000_0001);
    clear_counters();
    tick();
    issue(1'b1, 1'b1, 5'h0C, 32'h0000_0007);
    tick();
    cmd_valid = 1'b0;
    lat = 2;
`ifdef PLL_RECONFIG_MASTER_TIMEOUT_EN
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("tmo_latency", lat, 20);
    chk("tmo_rsp_error", rsp_error, 1'b1);
    chk("tmo_poll_reads", poll_rd, 9);
    chk("tmo_readdata", rsp_readdata, 32'h0000_0001);
    repeat (5) tick();
    chk("tmo_no_read_after", poll_rd, 9);
    chk("tmo_rsp_count", rsp_cnt, 1);
    chk("tmo_error_cleared", rsp_error, 1'b0);
`else
    repeat (60) tick();
    chk("stuck_no_rsp", rsp_cnt, 0);
    chk("stuck_rsp_error", rsp_error, 1'b0);
    chk("stuck_poll_reads", poll_rd, 30);
    chk("stuck_ready", cmd_ready, 1'b0);
    pulse_reset("stuck_rst");
`endif

    // Reset in the middle of a stalled write.
    load_slave(1000, 0, 32'h0, 32'h0);
    clear_counters();
    tick();
    issue(1'b1, 1'b0, 5'h0A, 32'h0000_BEEF);
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("stall_write_held", avm_m0_write, 1'b1);
    chk("stall_addr", avm_m0_address, 5'h0A);
    pulse_reset("midwr_rst");
    chk("midwr_addr_cleared", avm_m0_address, 5'h0);
    chk("midwr_readdata_cleared", rsp_readdata, 32'h0);
    wait_n = 0;
    repeat (5) tick();
    chk("midwr_no_rsp", rsp_cnt, 0);
    chk("midwr_no_write", wr_done, 0);
    fresh = '{1'b0, 1'b0, 5'h11, 32'h0, 0, 0, 32'h0, 32'h0BAD_F00D, 3, 1, 0, 1, 0, 32'h0BAD_F00D};
    run_vec(7, fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
